multiword_add_sequencer: RTL and testbench



---
 rtl/multiword_add_sequencer.sv | 157 +++++++++++++++
 tb/tb_multiword_add_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// rtl/multiword_add_sequencer.sv - WORDS x 16-bit adder sequenced over one shared 16-bit CLA pair
// Optional subtract support compiled in with macro SUB_EN.

module lookahead_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] s,
    output logic        co
);
    logic [15:0] g, p, cin;
    logic [3:0]  gg, gp, cg, cgin, t;

    // carries c1..c4 of a 4-bit lookahead block
    function automatic logic [3:0] cla4(input logic [3:0] gi, input logic [3:0] pi, input logic ci);
        logic [3:0] c;
        c[0] = gi[0] | (pi[0] & ci);
        c[1] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
        c[2] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & ci);
        c[3] = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0])
             | (pi[3] & pi[2] & pi[1] & pi[0] & ci);
        return c;
    endfunction

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        cin  = '0;
        gg   = '0;
        gp   = '0;
        t    = '0;
        for (int k = 0; k < 4; k++) begin
            t     = cla4(g[4*k +: 4], p[4*k +: 4], 1'b0);
            gg[k] = t[3];
            gp[k] = &p[4*k +: 4];
        end
        cg   = cla4(gg, gp, 1'b0);
        cgin = {cg[2:0], 1'b0};
        for (int k = 0; k < 4; k++) begin
            t                = cla4(g[4*k +: 4], p[4*k +: 4], cgin[k]);
            cin[4*k]         = cgin[k];
            cin[4*k+1 +: 3]  = t[2:0];
        end
        s  = p ^ cin;
        co = cg[3];
    end
endmodule

module multiword_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                start,
    input  logic                sub,
    input  logic [16*WORDS-1:0] A,
    input  logic [16*WORDS-1:0] B,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] S,
    output logic                CO
);
    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_reg, b_reg;
    logic [IW-1:0]   idx;
    logic            c;
    logic            last;
    logic [15:0]     a_slice, b_slice, b_op, t_sum, s_slice;
    logic            co1, co2, slice_c;

    assign a_slice = a_reg[{idx, 4'b0000} +: 16];
    assign b_slice = b_reg[{idx, 4'b0000} +: 16];
    assign last    = (idx == IW'(WORDS - 1));

`ifdef SUB_EN
    logic sub_reg;
    assign b_op = b_slice ^ {16{sub_reg}};
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_op       = b_slice;
`endif

    lookahead_adder u_add_ab (.a(a_slice), .b(b_op),            .s(t_sum),   .co(co1));
    lookahead_adder u_add_c  (.a(t_sum),   .b({15'b0, c}),      .s(s_slice), .co(co2));

    // the two stage carries are mutually exclusive, so OR is the true slice carry
    assign slice_c = co1 | co2;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            c     <= 1'b0;
            S     <= '0;
            CO    <= 1'b0;
`ifdef SUB_EN
            sub_reg <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_reg <= A;
                    b_reg <= B;
                    idx   <= '0;
`ifdef SUB_EN
                    sub_reg <= sub;
                    c       <= sub;
`else
                    c       <= 1'b0;
`endif
                end
                RUN: begin
                    S[{idx, 4'b0000} +: 16] <= s_slice;
                    c   <= slice_c;
                    idx <= idx + 1'b1;
                    if (last) CO <= slice_c;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb/tb_multiword_add_sequencer.sv - randomized self-checking bench for multiword_add_sequencer

module tb_multiword_add_sequencer;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         ready, busy, done, co;
    logic [W-1:0] s;

    int checks = 0;
    int errors = 0;

    multiword_add_sequencer #(.WORDS(WORDS)) dut (
        .Clk(clk), .Reset(rst), .start(start), .sub(sub), .A(a_in), .B(b_in),
        .ready(ready), .busy(busy), .done(done), .S(s), .CO(co)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb);
        logic [W:0] r;
`ifdef SUB_EN
        if (sb) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else    r = {1'b0, a} + {1'b0, b};
`else
        r = {1'b0, a} + {1'b0, b};
        if (sb) r = r;
`endif
        return r;
    endfunction

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb,
                          output logic [W-1:0] s_obs, output logic co_obs, output int lat);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin @(negedge clk); n++; end
        a_in = a; b_in = b; sub = sb; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a_in = rand_word(); b_in = rand_word(); sub = ~sb;
        lat = 1;
        while (!done && lat < 50) begin @(negedge clk); lat++; end
        s_obs  = s;
        co_obs = co;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (s !== '0)       begin errors++; $display("FAIL reset_s got %h want 0", s); end
        checks++; if (co !== 1'b0)    begin errors++; $display("FAIL reset_co got %b want 0", co); end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        logic         vs [4];
        logic [W-1:0] so;
        logic [W:0]   e;
        logic         cobs;
        int           lat;
        va[0] = 64'h0000_0000_0000_FFFF; vb[0] = 64'h1; vs[0] = 1'b0;
        va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'h1; vs[1] = 1'b0;
        va[2] = 64'd5;                   vb[2] = 64'd7; vs[2] = 1'b1;
        va[3] = 64'd7;                   vb[3] = 64'd5; vs[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vs[i], so, cobs, lat);
            e = model(va[i], vb[i], vs[i]);
            checks++; if (lat !== WORDS + 1) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, WORDS + 1); end
            checks++; if (so !== e[W-1:0]) begin errors++; $display("FAIL dir%0d_s got %h want %h", i, so, e[W-1:0]); end
            checks++; if (cobs !== e[W])   begin errors++; $display("FAIL dir%0d_co got %b want %b", i, cobs, e[W]); end
            @(negedge clk);
            checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL dir%0d_after_done got ready=%b done=%b want ready=1 done=0", i, ready, done); end
            if (i == 0) begin
                checks++; if (so !== 64'h0000_0000_0001_0000) begin errors++; $display("FAIL slice_carry_s got %h want 0000000000010000", so); end
            end
            if (i == 1) begin
                checks++; if (so !== 64'h0 || cobs !== 1'b1) begin errors++; $display("FAIL full_ripple got s=%h co=%b want s=0 co=1", so, cobs); end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, so;
        logic         sb, cobs;
        logic [W:0]   e;
        int           lat;
        for (int i = 0; i < 30; i++) begin
            a  = rand_word();
            b  = rand_word();
            sb = 1'($urandom_range(0, 1));
            if (i == 0) begin a = '1; b = '1; end
            if (i == 1) begin a = '0; b = '0; end
            run_op(a, b, sb, so, cobs, lat);
            e = model(a, b, sb);
            checks++; if (lat !== WORDS + 1) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, WORDS + 1); end
            checks++; if ({cobs, so} !== e) begin errors++; $display("FAIL rnd%0d_result got co=%b s=%h want co=%b s=%h", i, cobs, so, e[W], e[W-1:0]); end
        end
    endtask

    task automatic test_start_held();
        logic [W-1:0] a1, b1, a2, b2, s_first;
        logic [W:0]   e1, e2;
        int           ndone = 0;
        int           n = 0;
        a1 = rand_word(); b1 = rand_word();
        a2 = rand_word(); b2 = rand_word();
        s_first = '0;
        @(negedge clk);
        while (!ready && n < 50) begin @(negedge clk); n++; end
        a_in = a1; b_in = b1; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_in = a2; b_in = b2;
        if (done) begin ndone++; s_first = s; end
        for (int k = 2; k <= WORDS + 1; k++) begin
            @(negedge clk);
            if (done) begin ndone++; s_first = s; end
        end
        e1 = model(a1, b1, 1'b0);
        checks++; if (ndone !== 1) begin errors++; $display("FAIL held_done_count got %0d want 1", ndone); end
        checks++; if (s_first !== e1[W-1:0]) begin errors++; $display("FAIL held_s got %h want %h", s_first, e1[W-1:0]); end
        @(negedge clk);
        checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL held_idle got ready=%b done=%b want ready=1 done=0", ready, done); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_reaccept got busy=%b want 1", busy); end
        start = 1'b0;
        a_in = rand_word(); b_in = rand_word();
        n = 0;
        while (!done && n < 50) begin @(negedge clk); n++; end
        e2 = model(a2, b2, 1'b0);
        checks++; if ({co, s} !== e2) begin errors++; $display("FAIL held_second got co=%b s=%h want co=%b s=%h", co, s, e2[W], e2[W-1:0]); end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] so;
        logic         cobs;
        int           lat;
        int           ndone = 0;
        int           n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin @(negedge clk); n++; end
        a_in = rand_word(); b_in = rand_word(); sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got ready=%b busy=%b done=%b want 1 0 0", ready, busy, done); end
        checks++; if (s !== '0 || co !== 1'b0) begin errors++; $display("FAIL midrst_result got s=%h co=%b want 0 0", s, co); end
        for (int k = 0; k < WORDS + 3; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
        run_op(64'd3, 64'd4, 1'b0, so, cobs, lat);
        checks++; if (so !== 64'd7 || cobs !== 1'b0) begin errors++; $display("FAIL midrst_followup got s=%h co=%b want 7 0", so, cobs); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_held();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
